sync_debounce_edge: RTL and testbench
=====================================

Name: sync_debounce_edge

Overview:
- Consumer stage placed directly after a two-flop level synchronizer, in the destination clock domain.
- Takes the already-synchronized single-bit level and runs it through a stable-count debounce filter.
- Produces a clean debounced level, one-cycle rise and fall pulses, and a saturating rising-event counter for status registers.
- Provides no metastability protection; `din` must already be synchronous to `clk`.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive identical samples required to accept a level change (legal range ≥1).
- CNT_W, 5, width of the internal qualification counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- EVT_W, 8, width of the event and glitch counters.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- din  in  1  synchronized level input (synchronizer output).
- cnt_clr  in  1  synchronous clear of the event and glitch counters.
- level_out  out  1  debounced level (registered).
- rise_pulse  out  1  one-cycle pulse when level_out goes 0→1.
- fall_pulse  out  1  one-cycle pulse when level_out goes 1→0.
- rise_cnt  out  EVT_W  saturating count of accepted rising edges.
- glitch_cnt  out  EVT_W  saturating count of aborted qualifications (see Optional Feature).

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, named `reset`. All state changes only on posedge `clk`.
- Reset values (`reset`=1 at an edge):
  - state = STABLE_LO, qualification counter = 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0.
  - rise_cnt = 0, glitch_cnt = 0.
  - Reset overrides all other inputs, including mid-qualification; any partial count is discarded.
- States: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
- STABLE_LO:
  - din=0: stay.
  - din=1: go to QUAL_HI with qcnt=1. If DEBOUNCE_CYCLES=1, instead go straight to STABLE_HI and accept the change.
- QUAL_HI:
  - din=1: qcnt+1. When that sample makes qcnt equal DEBOUNCE_CYCLES, go to STABLE_HI, set level_out=1, assert rise_pulse on that same edge.
  - din=0: abort, return to STABLE_LO, qcnt=0, count a glitch.
- STABLE_HI and QUAL_LO: mirror images of the above; an accepted change sets level_out=0 and asserts fall_pulse.
- Latency: with din first sampled at its new value on edge k and held, level_out and the pulse update on edge k+DEBOUNCE_CYCLES-1. They are visible for the cycle after that edge.
- Pulses:
  - Exactly one cycle wide.
  - Never both asserted in the same cycle.
  - Deasserted on the next edge unconditionally.
- Counters:
  - rise_cnt increments on every accepted rise and saturates at all-ones (no wrap).
  - cnt_clr=1 zeroes rise_cnt and glitch_cnt.
  - Simultaneous cnt_clr and increment: clear wins, result 0.
  - cnt_clr has no effect on level_out, the pulses or the FSM.
- Width rules: qcnt never exceeds DEBOUNCE_CYCLES. Counters are unsigned.
- Invalid parameters: elaboration fails if DEBOUNCE_CYCLES<1 or 2^CNT_W ≤ DEBOUNCE_CYCLES.

Optional Feature:
- Macro: SYNC_DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - glitch_cnt increments by 1 on every aborted qualification (QUAL_HI→STABLE_LO or QUAL_LO→STABLE_HI).
  - Saturates at all-ones; same cnt_clr priority as rise_cnt.
- Undefined:
  - No glitch counter logic is built.
  - The glitch_cnt port remains present and is tied to 0, so the interface does not change.

Test Plan (DEBOUNCE_CYCLES=4, EVT_W=8 unless noted):
- Reset: hold reset 2 cycles with din=1 → level_out=0, pulses=0, rise_cnt=0, glitch_cnt=0. After release with din held 1, rise_pulse fires on the 4th edge after release.
- Clean rise then fall: din 0→1, held 10 cycles → level_out=1 on the 4th sampling edge, rise_pulse high exactly 1 cycle, rise_cnt=1. din→0 held 10 cycles → fall_pulse 1 cycle, level_out=0.
- Glitch rejection: din=1 for 3 cycles then 0 → level_out stays 0, no pulses, glitch_cnt=1 (macro defined) or 0 (undefined). Repeat 300 times → glitch_cnt saturates at 255.
- Counter clear: after 5 accepted rises, assert cnt_clr on the same edge as the 6th rise acceptance → rise_cnt=0 next cycle, rise_pulse still asserted.
- Reset mid-qualification: din=1 for 2 cycles, then reset 1 cycle with din still 1 → qualification restarts. level_out rises 4 edges after reset release, not earlier.
- DEBOUNCE_CYCLES=1: din toggles every cycle → level_out follows din with 1-cycle latency, alternating rise and fall pulses, glitch_cnt stays 0.

Source files
------------

// File: rtl/sync_debounce_edge_if.sv
// Signal bundle for sync_debounce_edge: synchronized level in, counter clear,
// debounced level, edge pulses and event counters out.
interface sync_debounce_edge_if #(
    parameter int EVT_W = 8
);
    logic             din;
    logic             cnt_clr;
    logic             level_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [EVT_W-1:0] rise_cnt;
    logic [EVT_W-1:0] glitch_cnt;

    modport master (
        output din, cnt_clr,
        input  level_out, rise_pulse, fall_pulse, rise_cnt, glitch_cnt
    );

    modport slave (
        input  din, cnt_clr,
        output level_out, rise_pulse, fall_pulse, rise_cnt, glitch_cnt
    );
endinterface

// File: rtl/sync_debounce_edge.sv
// Stable-count debounce of an already-synchronized level with edge pulses and
// saturating event counters. Define SYNC_DEBOUNCE_GLITCH_CNT_EN to build the glitch counter.
module sync_debounce_edge #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int EVT_W           = 8
) (
    input logic                 clk,
    input logic                 reset,
    sync_debounce_edge_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1 || (2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_bad_param
        $error("sync_debounce_edge: need DEBOUNCE_CYCLES >= 1 and 2**CNT_W > DEBOUNCE_CYCLES");
    end

    localparam logic [CNT_W-1:0] QMAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               FAST = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO,
        QUAL_HI,
        STABLE_HI,
        QUAL_LO
    } state_t;

    function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
        return (&v) ? v : v + EVT_W'(1);
    endfunction

    state_t           state;
    logic [CNT_W-1:0] qcnt;
    logic [CNT_W-1:0] qcnt_inc;
    logic             level;
    logic             rise;
    logic             fall;
    logic [EVT_W-1:0] rise_cnt;
    logic             accept_rise;
    logic             accept_fall;
    logic             abort;

    assign qcnt_inc = qcnt + CNT_W'(1);

    // Decisions for this edge, shared by the FSM and the counters.
    always_comb begin
        accept_rise = 1'b0;
        accept_fall = 1'b0;
        abort       = 1'b0;
        case (state)
            STABLE_LO: accept_rise = bus.din && FAST;
            QUAL_HI: begin
                if (bus.din) accept_rise = (qcnt_inc == QMAX);
                else         abort       = 1'b1;
            end
            STABLE_HI: accept_fall = !bus.din && FAST;
            QUAL_LO: begin
                if (!bus.din) accept_fall = (qcnt_inc == QMAX);
                else          abort       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LO;
            qcnt  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= accept_rise;
            fall <= accept_fall;
            case (state)
                STABLE_LO: begin
                    if (accept_rise) begin
                        state <= STABLE_HI;
                        level <= 1'b1;
                    end else if (bus.din) begin
                        state <= QUAL_HI;
                        qcnt  <= CNT_W'(1);
                    end
                end
                QUAL_HI: begin
                    if (abort) begin
                        state <= STABLE_LO;
                        qcnt  <= '0;
                    end else if (accept_rise) begin
                        state <= STABLE_HI;
                        qcnt  <= '0;
                        level <= 1'b1;
                    end else begin
                        qcnt <= qcnt_inc;
                    end
                end
                STABLE_HI: begin
                    if (accept_fall) begin
                        state <= STABLE_LO;
                        level <= 1'b0;
                    end else if (!bus.din) begin
                        state <= QUAL_LO;
                        qcnt  <= CNT_W'(1);
                    end
                end
                QUAL_LO: begin
                    if (abort) begin
                        state <= STABLE_HI;
                        qcnt  <= '0;
                    end else if (accept_fall) begin
                        state <= STABLE_LO;
                        qcnt  <= '0;
                        level <= 1'b0;
                    end else begin
                        qcnt <= qcnt_inc;
                    end
                end
                default: begin
                    state <= STABLE_LO;
                    qcnt  <= '0;
                end
            endcase
        end
    end

    // Clear has priority over a same-edge increment.
    always_ff @(posedge clk) begin
        if (reset || bus.cnt_clr) rise_cnt <= '0;
        else if (accept_rise)     rise_cnt <= sat_inc(rise_cnt);
    end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    logic [EVT_W-1:0] glitch_cnt;

    always_ff @(posedge clk) begin
        if (reset || bus.cnt_clr) glitch_cnt <= '0;
        else if (abort)           glitch_cnt <= sat_inc(glitch_cnt);
    end

    assign bus.glitch_cnt = glitch_cnt;
`else
    assign bus.glitch_cnt = '0;
`endif

    assign bus.level_out  = level;
    assign bus.rise_pulse = rise;
    assign bus.fall_pulse = fall;
    assign bus.rise_cnt   = rise_cnt;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: vector table at DEBOUNCE_CYCLES=4 plus
// hand sequences for counter clear, saturation and the DEBOUNCE_CYCLES=1 build.
module tb_sync_debounce_edge;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_debounce_edge_if #(.EVT_W(8)) bus_a ();
    sync_debounce_edge_if #(.EVT_W(8)) bus_b ();

    sync_debounce_edge #(.DEBOUNCE_CYCLES(4), .CNT_W(5), .EVT_W(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sync_debounce_edge #(.DEBOUNCE_CYCLES(1), .CNT_W(2), .EVT_W(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    localparam logic [7:0] G1   = 8'd1;
    localparam logic [7:0] GSAT = 8'd255;
`else
    localparam logic [7:0] G1   = 8'd0;
    localparam logic [7:0] GSAT = 8'd0;
`endif

    typedef struct {
        logic       rst;
        logic       din;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] rcnt;
        logic [7:0] gcnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses_seen;

    task automatic add(input logic [5:0] b, input logic [7:0] rc, input logic [7:0] gc);
        vec_t v;
        {v.rst, v.din, v.clr, v.lvl, v.rise, v.fall} = b;
        v.rcnt = rc;
        v.gcnt = gc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus_a.rise_pulse || bus_a.fall_pulse) pulses_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rise_fall();
        bus_a.din = 1'b1;
        repeat (4) tick();
        bus_a.din = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic prev;
        logic [7:0] exp_rc;
        logic [4:0] pattern;

        bus_a.din = 1'b0; bus_a.cnt_clr = 1'b0;
        bus_b.din = 1'b0; bus_b.cnt_clr = 1'b0;
        pulses_seen = 0;

        // {rst, din, clr, lvl, rise, fall}, rise_cnt, glitch_cnt
        add(6'b110_000, 8'd0, 8'd0);
        add(6'b110_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_110, 8'd1, 8'd0);
        add(6'b010_100, 8'd1, 8'd0);
        add(6'b010_100, 8'd1, 8'd0);
        add(6'b000_100, 8'd1, 8'd0);
        add(6'b000_100, 8'd1, 8'd0);
        add(6'b000_100, 8'd1, 8'd0);
        add(6'b000_001, 8'd1, 8'd0);
        add(6'b000_000, 8'd1, 8'd0);
        add(6'b010_000, 8'd1, 8'd0);
        add(6'b010_000, 8'd1, 8'd0);
        add(6'b010_000, 8'd1, 8'd0);
        add(6'b000_000, 8'd1, G1);
        add(6'b000_000, 8'd1, G1);
        add(6'b010_000, 8'd1, G1);
        add(6'b010_000, 8'd1, G1);
        add(6'b110_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_000, 8'd0, 8'd0);
        add(6'b010_110, 8'd1, 8'd0);
        add(6'b011_100, 8'd0, 8'd0);
        add(6'b000_100, 8'd0, 8'd0);
        add(6'b000_100, 8'd0, 8'd0);
        add(6'b010_100, 8'd0, G1);
        add(6'b010_100, 8'd0, G1);
        add(6'b000_100, 8'd0, G1);
        add(6'b000_100, 8'd0, G1);
        add(6'b000_100, 8'd0, G1);
        add(6'b000_001, 8'd0, G1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            reset         = vecs[i].rst;
            bus_a.din     = vecs[i].din;
            bus_a.cnt_clr = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_level", i), 32'(bus_a.level_out), 32'(vecs[i].lvl));
            chk($sformatf("vec%0d_rise", i), 32'(bus_a.rise_pulse), 32'(vecs[i].rise));
            chk($sformatf("vec%0d_fall", i), 32'(bus_a.fall_pulse), 32'(vecs[i].fall));
            chk($sformatf("vec%0d_rise_cnt", i), 32'(bus_a.rise_cnt), 32'(vecs[i].rcnt));
            chk($sformatf("vec%0d_glitch_cnt", i), 32'(bus_a.glitch_cnt), 32'(vecs[i].gcnt));
        end
        bus_a.cnt_clr = 1'b0;
        bus_a.din     = 1'b0;

        // Clear on the same edge as the sixth accepted rise
        do_reset();
        repeat (5) rise_fall();
        chk("five_rises_cnt", 32'(bus_a.rise_cnt), 32'd5);
        bus_a.din = 1'b1;
        repeat (3) tick();
        bus_a.cnt_clr = 1'b1;
        tick();
        bus_a.cnt_clr = 1'b0;
        chk("clr_rise_pulse", 32'(bus_a.rise_pulse), 32'd1);
        chk("clr_level", 32'(bus_a.level_out), 32'd1);
        chk("clr_rise_cnt", 32'(bus_a.rise_cnt), 32'd0);
        tick();
        chk("clr_pulse_drop", 32'(bus_a.rise_pulse), 32'd0);
        bus_a.din = 1'b0;
        repeat (4) tick();
        chk("clr_fall_level", 32'(bus_a.level_out), 32'd0);

        // rise_cnt saturation
        do_reset();
        repeat (260) rise_fall();
        chk("rise_cnt_sat", 32'(bus_a.rise_cnt), 32'd255);

        // Glitch storm: 300 aborted qualifications
        do_reset();
        pulses_seen = 0;
        repeat (300) begin
            bus_a.din = 1'b1;
            repeat (3) tick();
            bus_a.din = 1'b0;
            tick();
        end
        chk("storm_glitch_cnt", 32'(bus_a.glitch_cnt), 32'(GSAT));
        chk("storm_level", 32'(bus_a.level_out), 32'd0);
        chk("storm_pulses", 32'(pulses_seen), 32'd0);
        chk("storm_rise_cnt", 32'(bus_a.rise_cnt), 32'd0);

        // DEBOUNCE_CYCLES=1: level tracks din one edge later
        do_reset();
        prev   = 1'b0;
        exp_rc = 8'd0;
        pattern = 5'b01101;
        for (int i = 0; i < 12; i++) begin
            bus_b.din = (i < 5) ? pattern[i] : logic'(i % 2);
            tick();
            if (bus_b.din && !prev) exp_rc++;
            chk($sformatf("d1_level%0d", i), 32'(bus_b.level_out), 32'(bus_b.din));
            chk($sformatf("d1_rise%0d", i), 32'(bus_b.rise_pulse), 32'(bus_b.din && !prev));
            chk($sformatf("d1_fall%0d", i), 32'(bus_b.fall_pulse), 32'(!bus_b.din && prev));
            chk($sformatf("d1_rise_cnt%0d", i), 32'(bus_b.rise_cnt), 32'(exp_rc));
            chk($sformatf("d1_glitch%0d", i), 32'(bus_b.glitch_cnt), 32'd0);
            prev = bus_b.din;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
